dmem_access_ctrl: RTL
=====================

# dmem_access_ctrl

Memory-stage data-access controller for the SELEN core. It converts load/store commands in the M stage into a request/acknowledge transaction on the data-memory bus and asserts a stall toward the hazard unit (its `stall_in`) while the access is outstanding. It also pulses completion (the hazard unit's `done_in`), returns registered load data to the W-stage mux, and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, 255: BUSY cycles without `dmem_ack` before the access is abandoned (1..255).
- `clk` input 1: core clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_inM` input 2: M-stage command; 2'b11 load, 2'b10 store, 2'b01/2'b00 no access.
- `flashM` input 1: M stage is being flushed; suppresses starting a new access.
- `addrM` input 32: byte address from the M stage.
- `wdataM` input 32: store data from the M stage.
- `dmem_req` output 1: bus request, registered.
- `dmem_we` output 1: 1 store, 0 load; valid while `dmem_req`.
- `dmem_addr` output 32: latched word address; `[1:0]` always 0.
- `dmem_wdata` output 32: latched store data.
- `dmem_ack` input 1: bus acknowledge; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` input 32: load data.
- `stall_out` output 1: to the hazard unit `stall_in`; freezes the pipeline.
- `done_out` output 1: one-cycle completion pulse, to the hazard unit `done_in`.
- `rdata_out` output 32: last load data, registered.
- `misalign_out` output 1: combinational; the access in M has `addrM[1:0]` ≠ 0.
- `bus_err_out` output 1: one-cycle pulse; the access timed out.

## Operation
- Definition: `start` = (state = IDLE) & `cmd_inM[1]` & ~`flashM` & (`addrM[1:0]` = 0).
- State machine, states IDLE, BUSY, DONE:
  - IDLE → BUSY on `start`. Latch `addrM`, `wdataM`, and `dmem_we` = `cmd_inM[0]` inverted (1 for store). Set `dmem_req` = 1. Clear the timeout counter.
  - BUSY → DONE on `dmem_ack`. Clear `dmem_req`. For a load, capture `dmem_rdata` into `rdata_out`.
  - BUSY → DONE when the counter reaches `TIMEOUT` without `dmem_ack`. Clear `dmem_req`, set the bus-error flag, leave `rdata_out` unchanged.
  - DONE → IDLE unconditionally.
- `stall_out` = `start` | (state = BUSY). It is combinational, so the pipeline freezes in the same cycle the access is first seen.
- `done_out` = (state = DONE). `bus_err_out` = (state = DONE) & error flag. The error flag clears on leaving DONE.
- In DONE, `stall_out` = 0, so the M stage advances at the end of DONE. Because DONE never evaluates `start`, the same instruction is never re-issued.
- Misaligned load/store (`cmd_inM[1]` = 1, `addrM[1:0]` ≠ 0): no request and no stall. `misalign_out` = 1 while it sits in M.
- `flashM` while in IDLE: no request. `flashM` while in BUSY or DONE: ignored; an issued transaction always completes.
- `dmem_ack` outside BUSY: ignored.
- Stores never modify `rdata_out`.
- Timeout counter is 8 bits, increments each BUSY cycle without ack, and saturates.

## Timing
- Reset values: state IDLE; `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0, `rdata_out` 0; error flag 0; counter 0.
- With reset inactive and `cmd_inM[1]` = 0: `stall_out` 0, `done_out` 0, `misalign_out` 0, `bus_err_out` 0.
- Reset asserted mid-access: `dmem_req` drops asynchronously and state returns to IDLE. There is no completion pulse.
- Cycle 0: access in M; `stall_out` = 1.
- Cycle 1: BUSY; `dmem_req` = 1.
- Ack in cycle k ≥ 1: `rdata_out` is valid from cycle k+1 (DONE, `done_out` = 1, `stall_out` = 0).
- Minimum occupancy in M is 3 cycles.
- Timeout: `dmem_req` is high for exactly `TIMEOUT` cycles, then DONE with `bus_err_out` = 1.
- Back-to-back accesses: the next instruction is in M in the cycle after DONE, so a new `start` can occur there. `dmem_req` is low for at least 2 cycles between transactions.

## Test plan
- Load, `addrM` = 0x100, ack in the first BUSY cycle with `dmem_rdata` = 0xDEADBEEF → `stall_out` high for 2 cycles, `dmem_we` = 0, `done_out` in cycle 2, `rdata_out` = 0xDEADBEEF.
- Store, `addrM` = 0x204, `wdataM` = 0x12345678, ack after 5 cycles → `dmem_we` = 1, `dmem_addr` = 0x204 and `dmem_wdata` = 0x12345678 held stable for all 5 request cycles, `rdata_out` unchanged.
- `TIMEOUT` = 4, no ack → `dmem_req` high for 4 cycles, then `done_out` = 1 and `bus_err_out` = 1 for 1 cycle, `rdata_out` unchanged.
- Load with `addrM` = 0x102 → `misalign_out` = 1, `stall_out` = 0, `dmem_req` never asserted.
- `flashM` = 1 with a load in IDLE → no request. `flashM` raised in BUSY → request still completes and `done_out` pulses.
- `reset_n` low in BUSY → `dmem_req` = 0 immediately, no `done_out`. After release, a load at 0x8 proceeds normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Memory-stage data-access controller. Turns an aligned load/store sitting in
// the M stage into a req/ack transaction on the data-memory bus, stalls the
// pipeline while the access is outstanding, pulses completion for one cycle,
// keeps the last load data in a register for the W-stage mux, and flags
// misaligned accesses and bus timeouts.
//
// Ports
//   clk, reset_n   core clock (rising edge), asynchronous active-low reset
//   cmd_inM        M-stage command: 2'b11 load, 2'b10 store, 2'b0x no access
//   flashM         M stage is being flushed; blocks starting a new access
//   addrM, wdataM  byte address and store data from the M stage
//   dmem_req       registered bus request
//   dmem_we        1 store / 0 load, valid while dmem_req
//   dmem_addr      latched word address (bits [1:0] always 0)
//   dmem_wdata     latched store data
//   dmem_ack       bus acknowledge; dmem_rdata valid in the same cycle
//   dmem_rdata     load data from the bus
//   stall_out      freeze the pipeline (hazard unit stall_in)
//   done_out       one-cycle completion pulse (hazard unit done_in)
//   rdata_out      last load data, registered
//   misalign_out   access in M has a non-word-aligned address
//   bus_err_out    one-cycle pulse: the access was abandoned on timeout
//
// Parameters
//   TIMEOUT        BUSY cycles without ack before the access is abandoned
//                  (1..255)
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  cmd_inM,
   input  logic        flashM,
   input  logic [31:0] addrM,
   input  logic [31:0] wdataM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        done_out,
   output logic [31:0] rdata_out,
   output logic        misalign_out,
   output logic        bus_err_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter holds the number of BUSY cycles already spent without ack,
   // so the TIMEOUT-th such cycle is the one where it reads TIMEOUT-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic       err;
   logic       aligned;
   logic       start;
   logic       timeout_hit;

   assign aligned      = (addrM[1:0] == 2'b00);
   assign start        = (state == IDLE) && cmd_inM[1] && !flashM && aligned;
   assign timeout_hit  = (state == BUSY) && !dmem_ack && (cnt == CNT_LAST);

   assign stall_out    = start || (state == BUSY);
   assign done_out     = (state == DONE);
   assign bus_err_out  = (state == DONE) && err;
   assign misalign_out = cmd_inM[1] && !aligned;

   // NOTE: every output of a combinational block gets a default on entry; a
   // path that leaves it unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = BUSY;
         BUSY: if (dmem_ack || timeout_hit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         rdata_out  <= '0;
         err        <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= ~cmd_inM[0];
                  dmem_addr  <= {addrM[31:2], 2'b00};
                  dmem_wdata <= wdataM;
                  cnt        <= '0;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) rdata_out <= dmem_rdata;
               end else if (timeout_hit) begin
                  dmem_req <= 1'b0;
                  err      <= 1'b1;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               err <= 1'b0;
            end
            default: begin
               dmem_req <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule
